// File: rtl/latent_seed_streamer_pkg.sv
// rtl/latent_seed_streamer_pkg.sv - shared state encodings and sizing helper for the seed streamer
// Common to the seed bank, this streamer and the generator top.
package latent_seed_streamer_pkg;

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_LOADED = 2'd1,
    S_STREAM = 2'd2
  } state_e;

  // Index width for a count; never narrower than one bit.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/latent_seed_streamer_scale_sat.sv
// rtl/latent_seed_streamer_scale_sat.sv - combinational Q8.8 scaling with optional saturation
// SEED_STREAM_CLAMP_EN adds saturation to [-CLAMP_MAG, +CLAMP_MAG].
module seed_scale_sat #(
  parameter int DATA_WIDTH  = 16,
  parameter int SCALE_SHIFT = 2
`ifdef SEED_STREAM_CLAMP_EN
  ,
  parameter logic [DATA_WIDTH-1:0] CLAMP_MAG = 16'h0100
`endif
) (
  input  logic [DATA_WIDTH-1:0] word_i,
  output logic [DATA_WIDTH-1:0] scaled_o
);

  logic signed [DATA_WIDTH-1:0] shifted;

  // Arithmetic shift floors toward -inf, matching the latent scaling.
  assign shifted = $signed(word_i) >>> SCALE_SHIFT;

`ifdef SEED_STREAM_CLAMP_EN
  localparam logic signed [DATA_WIDTH-1:0] POS_MAG = CLAMP_MAG;
  localparam logic signed [DATA_WIDTH-1:0] NEG_MAG = -POS_MAG;

  always_comb begin
    scaled_o = shifted;
    if (shifted > POS_MAG) begin
      scaled_o = POS_MAG;
    end else if (shifted < NEG_MAG) begin
      scaled_o = NEG_MAG;
    end
  end
`else
  assign scaled_o = shifted;
`endif

endmodule

// File: rtl/latent_seed_streamer.sv
// rtl/latent_seed_streamer.sv - captures a seed bank and streams scaled latent beats over valid/ready
// Optional saturation is selected with SEED_STREAM_CLAMP_EN.
module latent_seed_streamer
  import latent_seed_streamer_pkg::*;
#(
  parameter int                    SEED_COUNT  = 64,
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    SCALE_SHIFT = 2,
  parameter logic [DATA_WIDTH-1:0] CLAMP_MAG   = 16'h0100
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             bank_valid,
  input  logic [DATA_WIDTH*SEED_COUNT-1:0] bank_flat,
  input  logic                             start,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [clog2(SEED_COUNT)-1:0]     out_index,
  output logic                             out_last,
  output logic                             bank_loaded,
  output logic                             busy,
  output logic                             stream_done,
  output logic                             overrun
);

  localparam int IDX_W = clog2(SEED_COUNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEED_COUNT - 1);

  state_e                         state_q, state_d;
  logic [DATA_WIDTH*SEED_COUNT-1:0] bank_q, bank_d;
  logic [IDX_W-1:0]               idx_q, idx_d, nxt_idx, sel_idx;
  logic [DATA_WIDTH-1:0]          data_q, data_d, sel_word, sel_scaled;
  logic valid_q, valid_d, last_q, last_d, done_q, done_d;
  logic loaded_q, loaded_d, overrun_q, overrun_d;
  logic xfer;

  assign xfer    = valid_q && out_ready;
  assign nxt_idx = idx_q + 1'b1;

  // The converter always looks at the word that the next output load will need.
  assign sel_idx  = (state_q == S_STREAM && idx_q != LAST_IDX) ? nxt_idx : '0;
  assign sel_word = bank_q[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];

  seed_scale_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .SCALE_SHIFT(SCALE_SHIFT)
`ifdef SEED_STREAM_CLAMP_EN
    ,
    .CLAMP_MAG  (CLAMP_MAG)
`endif
  ) u_scale (
    .word_i  (sel_word),
    .scaled_o(sel_scaled)
  );

  always_comb begin
    state_d   = state_q;
    bank_d    = bank_q;
    idx_d     = idx_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    done_d    = 1'b0;
    loaded_d  = loaded_q;
    overrun_d = overrun_q;
    case (state_q)
      S_EMPTY: begin
        if (bank_valid) begin
          bank_d   = bank_flat;
          loaded_d = 1'b1;
          state_d  = S_LOADED;
        end
      end
      S_LOADED: begin
        // A fresh bank wins over a simultaneous start; that start is dropped.
        if (bank_valid) begin
          bank_d = bank_flat;
        end else if (start) begin
          state_d = S_STREAM;
          idx_d   = '0;
          valid_d = 1'b1;
          data_d  = sel_scaled;
          last_d  = (LAST_IDX == '0);
        end
      end
      S_STREAM: begin
        if (bank_valid) begin
          overrun_d = 1'b1;
        end
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_LOADED;
          end else begin
            idx_d  = nxt_idx;
            data_d = sel_scaled;
            last_d = (nxt_idx == LAST_IDX);
          end
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_EMPTY;
      bank_q    <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      loaded_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bank_q    <= bank_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      done_q    <= done_d;
      loaded_q  <= loaded_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign out_index   = idx_q;
  assign out_last    = last_q;
  assign bank_loaded = loaded_q;
  assign busy        = (state_q == S_STREAM);
  assign stream_done = done_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_latent_seed_streamer.sv
// tb/tb_latent_seed_streamer.sv - scoreboard bench for latent_seed_streamer
// Randomized banks and ready; expected beats come from a floor-division reference model.
module tb_latent_seed_streamer;

  localparam int N  = 64;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            bank_valid = 1'b0;
  logic [DW*N-1:0] bank_flat = '0;
  logic            start = 1'b0;
  logic            out_ready = 1'b0;
  logic            out_valid, out_last, bank_loaded, busy, stream_done, overrun;
  logic [DW-1:0]   out_data;
  logic [5:0]      out_index;

  latent_seed_streamer #(
    .SEED_COUNT (N),
    .DATA_WIDTH (DW),
    .SCALE_SHIFT(2),
    .CLAMP_MAG  (16'h0100)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bank_valid (bank_valid),
    .bank_flat  (bank_flat),
    .start      (start),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_last   (out_last),
    .bank_loaded(bank_loaded),
    .busy       (busy),
    .stream_done(stream_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic [5:0]  idx;
    logic        last;
  } beat_t;

  beat_t       sb[$];
  logic [15:0] model_bank[N];
  logic [15:0] new_bank[N];
  int          vectors = 0;
  int          miscompares = 0;
  bit          ready_random = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Latent value = floor(word / 4), optionally saturated to +/-1.0.
  function automatic logic [15:0] model(input logic [15:0] w);
    int v, q;
    v = int'($signed(w));
    q = v / 4;
    if (v < 0 && (v % 4) != 0) q--;
`ifdef SEED_STREAM_CLAMP_EN
    if (q > 256) q = 256;
    if (q < -256) q = -256;
`endif
    return q[15:0];
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = ready_random ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops on each transfer, checks hold-while-stalled and the done pulse.
  initial begin
    bit          stall;
    bit          expect_done;
    logic [15:0] hold_data;
    logic [5:0]  hold_idx;
    beat_t       e;
    stall = 0;
    expect_done = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 0;
        expect_done = 0;
      end else begin
        if (expect_done || stream_done) check("stream_done", stream_done, expect_done);
        expect_done = 0;
        if (stall) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, hold_data);
          check("hold_index", out_index, hold_idx);
        end
        if (out_valid && out_ready) begin
          stall = 0;
          if (sb.size() == 0) begin
            check("unexpected_beat", 1, 0);
          end else begin
            e = sb.pop_front();
            check("beat_data", out_data, e.data);
            check("beat_index", out_index, e.idx);
            check("beat_last", out_last, e.last);
            if (e.last) expect_done = 1;
          end
        end else if (out_valid) begin
          stall = 1;
          hold_data = out_data;
          hold_idx = out_index;
        end else begin
          stall = 0;
        end
      end
    end
  end

  task automatic random_bank();
    foreach (new_bank[i]) new_bank[i] = 16'($urandom_range(0, 65535));
  endtask

  task automatic pulse_bank();
    @(posedge clk);
    #1;
    foreach (new_bank[i]) bank_flat[i*DW +: DW] = new_bank[i];
    bank_valid = 1'b1;
    @(posedge clk);
    #1;
    bank_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic start_stream();
    foreach (model_bank[i]) sb.push_back(beat_t'{model(model_bank[i]), 6'(i), (i == N - 1)});
    check("pre_start_valid", out_valid, 0);
    pulse_start();
    check("start_latency", out_valid, 1);
    check("start_busy", busy, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 2000) check("drain_timeout", 1, 0);
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", busy, 0);
    check("idle_valid", out_valid, 0);
  endtask

  task automatic wait_index(input logic [5:0] k);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(out_valid && out_index == k) && n < 2000);
    if (n >= 2000) check("wait_index_timeout", 1, 0);
  endtask

  initial begin
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_loaded", bank_loaded, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_index", out_index, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Start with nothing loaded is ignored.
    pulse_start();
    repeat (2) @(posedge clk);
    #1;
    check("empty_start_busy", busy, 0);
    check("empty_start_valid", out_valid, 0);

    // Case 1: known first word, full-rate consumer.
    random_bank();
    new_bank[0] = 16'hACE1;
    new_bank[5] = 16'h0200;
    pulse_bank();
    model_bank = new_bank;
    check("loaded", bank_loaded, 1);
    start_stream();
`ifdef SEED_STREAM_CLAMP_EN
    check("beat0_const", out_data, 16'hFF00);
`else
    check("beat0_const", out_data, 16'hEB38);
`endif
    check("beat0_index", out_index, 0);
    drain();

    // Case 3: replay with a randomly stalling consumer; mid-stream start ignored.
    ready_random = 1'b1;
    start_stream();
    repeat (20) @(posedge clk);
    pulse_start();
    drain();
    ready_random = 1'b0;

    // Case 4: bank_valid mid-stream only flags overrun.
    check("overrun_before", overrun, 0);
    start_stream();
    wait_index(6'd10);
    random_bank();
    pulse_bank();
    check("overrun_set", overrun, 1);
    drain();
    check("overrun_sticky", overrun, 1);
    check("loaded_after_overrun", bank_loaded, 1);
    ready_random = 1'b1;
    start_stream();
    drain();
    ready_random = 1'b0;

    // Case 5: bank_valid beats start in the same cycle.
    random_bank();
    @(posedge clk);
    #1;
    foreach (new_bank[i]) bank_flat[i*DW +: DW] = new_bank[i];
    bank_valid = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    bank_valid = 1'b0;
    start = 1'b0;
    model_bank = new_bank;
    repeat (3) @(posedge clk);
    #1;
    check("collide_busy", busy, 0);
    check("collide_valid", out_valid, 0);
    start_stream();
    drain();

    // Case 6: reset mid-stream.
    start_stream();
    wait_index(6'd30);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_loaded", bank_loaded, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_done", stream_done, 0);
    check("midrst_data", out_data, 0);
    check("midrst_index", out_index, 0);
    check("midrst_last", out_last, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    check("postrst_start_busy", busy, 0);
    check("postrst_start_valid", out_valid, 0);
    random_bank();
    pulse_bank();
    model_bank = new_bank;
    ready_random = 1'b1;
    start_stream();
    drain();
    check("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
